// File: rtl/mem_access_if.sv
// Memory-side bus of the MEM stage: request/strobe/address/data out, one-cycle ack with read data back.
interface mem_access_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: stalls the pipe around one multi-cycle memory access, passes control through otherwise.
// Optional WAIT timeout with a one-cycle mem_err pulse is built when MEM_TIMEOUT_EN is defined.
//
//   state  | meaning
//   IDLE   | pass-through; an access raises stall and latches addr/data/we
//   WAIT   | mem_req held with latched values until mem_ack (or timeout)
//   DONE   | stall released, Mem_out_next = captured load data, back to IDLE
module mem_access_stage #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_if.master      bus,

    input  logic              valid_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [1:0]        RegDst_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic              run_in,
    input  logic              call_in,
    input  logic [3:0]        Rd_in,
    input  logic [15:0]       pc_addr_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] store_data_in,

    output logic [1:0]        RegDst_next,
    output logic              MemtoReg_next,
    output logic              RegWrite_next,
    output logic              run_next,
    output logic              call_next,
    output logic [3:0]        Rd_next,
    output logic [15:0]       pc_addr_next,
    output logic [DATA_W-1:0] ALU_result_next,
    output logic [DATA_W-1:0] Mem_out_next,
    output logic              stall,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_access;
    logic              w_timeout;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_rdata;

    assign w_access = valid_in & (MemRead_in | MemWrite_in);

`ifdef MEM_TIMEOUT_EN
    // Down-counter loaded on entry to WAIT; terminal count in WAIT without ack aborts the access.
    localparam logic [3:0] CNT_LOAD = 4'(TIMEOUT - 1);

    logic [3:0] r_cnt;
    logic       r_tmo;

    assign w_timeout = (r_state == S_WAIT) && !bus.mem_ack && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_tmo <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_access)
                r_cnt <= CNT_LOAD;
            else if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            r_tmo <= w_timeout;
        end
    end

    assign mem_err = r_tmo;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_access) w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.mem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Both MemRead and MemWrite set is a store, so only MemWrite is latched as the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_access) begin
                r_addr  <= ALU_result_in;
                r_wdata <= store_data_in;
                r_we    <= MemWrite_in;
            end
            if (r_state == S_WAIT && bus.mem_ack)
                r_rdata <= r_we ? '0 : bus.mem_rdata;
            else if (w_timeout)
                r_rdata <= '0;
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    always_comb begin
        RegDst_next     = RegDst_in;
        MemtoReg_next   = MemtoReg_in;
        RegWrite_next   = RegWrite_in;
        run_next        = run_in;
        call_next       = call_in;
        Rd_next         = Rd_in;
        pc_addr_next    = pc_addr_in;
        ALU_result_next = ALU_result_in;
        Mem_out_next    = '0;
        stall           = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        unique case (r_state)
            S_IDLE: stall = w_access & rst_n;
            S_WAIT: begin
                stall       = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = r_we;
            end
            S_DONE: begin
                Mem_out_next = r_rdata;
`ifdef MEM_TIMEOUT_EN
                if (r_tmo) RegWrite_next = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: random instruction stream, behavioural memory responder with stray acks.
module tb_mem_access_stage;

    localparam int DW  = 16;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(DW)) bus ();

    logic          valid_in = 0, MemRead_in = 0, MemWrite_in = 0;
    logic [1:0]    RegDst_in = 0;
    logic          MemtoReg_in = 0, RegWrite_in = 0, run_in = 0, call_in = 0;
    logic [3:0]    Rd_in = 0;
    logic [15:0]   pc_addr_in = 0;
    logic [DW-1:0] ALU_result_in = 0, store_data_in = 0;

    logic [1:0]    RegDst_next;
    logic          MemtoReg_next, RegWrite_next, run_next, call_next;
    logic [3:0]    Rd_next;
    logic [15:0]   pc_addr_next;
    logic [DW-1:0] ALU_result_next, Mem_out_next;
    logic          stall, mem_err;

    mem_access_stage #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .valid_in(valid_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegDst_in(RegDst_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .run_in(run_in), .call_in(call_in), .Rd_in(Rd_in), .pc_addr_in(pc_addr_in),
        .ALU_result_in(ALU_result_in), .store_data_in(store_data_in),
        .RegDst_next(RegDst_next), .MemtoReg_next(MemtoReg_next), .RegWrite_next(RegWrite_next),
        .run_next(run_next), .call_next(call_next), .Rd_next(Rd_next), .pc_addr_next(pc_addr_next),
        .ALU_result_next(ALU_result_next), .Mem_out_next(Mem_out_next),
        .stall(stall), .mem_err(mem_err)
    );

    typedef struct {
        logic        valid, mrd, mwr;
        logic [1:0]  regdst;
        logic        memtoreg, regwrite, run, call;
        logic [3:0]  rd;
        logic [15:0] pc, alu, sdata, rdata;
        int          n;   // WAIT cycles before ack; 0 = never acked
    } txn_t;

    typedef struct packed {
        logic [1:0]  regdst;
        logic        memtoreg, regwrite, run, call;
        logic [3:0]  rd;
        logic [15:0] pc, alu, memout;
        logic        err;
    } out_t;

    typedef struct {
        logic [15:0] addr, wdata, rdata;
        logic        we;
        int          n;
    } memx_t;

    out_t  exp_q[$];
    int    stall_q[$];
    memx_t mem_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    bit stray_force = 0;

    // ---------------- monitor: one presentation (stall=0) per instruction ----------------
    initial begin : monitor
        int   stall_cnt;
        out_t got, exp;
        int   exp_st;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) stall_cnt = 0;
            else if (stall) stall_cnt++;
            else begin
                got = '{RegDst_next, MemtoReg_next, RegWrite_next, run_next, call_next,
                        Rd_next, pc_addr_next, ALU_result_next, Mem_out_next, mem_err};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%h required=none", got);
                end else begin
                    exp    = exp_q.pop_front();
                    exp_st = stall_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL mem_wb_outputs got=%h required=%h", got, exp);
                    end
                    checks++;
                    if (stall_cnt != exp_st) begin
                        errors++;
                        $display("FAIL stall_cycles got=%0d required=%0d", stall_cnt, exp_st);
                    end
                end
                stall_cnt = 0;
            end
        end
    end

    // ---------------- memory responder with stray acks outside requests ----------------
    initial begin : responder
        bit    prev_req;
        int    k;
        memx_t cur;
        prev_req = 0;
        k = 0;
        cur = '{16'h0, 16'h0, 16'h0, 1'b0, 0};
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (!prev_req) begin
                    k = 0;
                    checks++;
                    if (mem_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_mem_req addr=%h required=no_request", bus.mem_addr);
                    end else cur = mem_q.pop_front();
                end
                k++;
                checks++;
                if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {cur.addr, cur.we, cur.wdata}) begin
                    errors++;
                    $display("FAIL mem_bus addr/we/wdata got=%h/%b/%h required=%h/%b/%h",
                             bus.mem_addr, bus.mem_we, bus.mem_wdata, cur.addr, cur.we, cur.wdata);
                end
                bus.mem_ack   = (cur.n != 0 && k == cur.n);
                bus.mem_rdata = bus.mem_ack ? cur.rdata : 16'($urandom);
            end else begin
                bus.mem_ack   = stray_force || ($urandom_range(0, 3) == 0);
                bus.mem_rdata = 16'($urandom);
            end
            prev_req = (bus.mem_req === 1'b1);
        end
    end

    // ---------------- reference model and driver ----------------
    task automatic send(input txn_t t, input bit chk);
        bit   access, tmo, done;
        out_t e;
        access = t.valid && (t.mrd || t.mwr);
        tmo    = access && (t.n == 0);
        if (access) mem_q.push_back('{t.alu, t.sdata, t.rdata, t.mwr, t.n});
        if (chk) begin
            e.regdst   = t.regdst;
            e.memtoreg = t.memtoreg;
            e.regwrite = tmo ? 1'b0 : t.regwrite;
            e.run      = t.run;
            e.call     = t.call;
            e.rd       = t.rd;
            e.pc       = t.pc;
            e.alu      = t.alu;
            e.memout   = (access && !t.mwr && !tmo) ? t.rdata : 16'h0;
            e.err      = tmo;
            exp_q.push_back(e);
            stall_q.push_back(!access ? 0 : (tmo ? 1 + TMO : 1 + t.n));
        end
        valid_in = t.valid; MemRead_in = t.mrd; MemWrite_in = t.mwr;
        RegDst_in = t.regdst; MemtoReg_in = t.memtoreg; RegWrite_in = t.regwrite;
        run_in = t.run; call_in = t.call; Rd_in = t.rd; pc_addr_in = t.pc;
        ALU_result_in = t.alu; store_data_in = t.sdata;
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stall) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_release got=stuck required=release_within_64");
        end
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   kind;
        kind = $urandom_range(0, 4);
        t.valid    = (kind != 0);
        t.mrd      = (kind == 0) ? 1'($urandom) : (kind == 2 || kind == 4);
        t.mwr      = (kind == 0) ? 1'($urandom) : (kind == 3 || kind == 4);
        t.regdst   = 2'($urandom);
        t.memtoreg = 1'($urandom);
        t.regwrite = 1'($urandom);
        t.run      = 1'($urandom);
        t.call     = 1'($urandom);
        t.rd       = 4'($urandom);
        t.pc       = 16'($urandom);
        t.alu      = 16'($urandom);
        t.sdata    = 16'($urandom);
        t.rdata    = 16'($urandom);
        t.n        = $urandom_range(1, 4);
        return t;
    endfunction

    function automatic txn_t mk(input logic v, input logic r, input logic w, input logic [15:0] a,
                                input logic [15:0] sd, input logic [15:0] rdat, input int n);
        txn_t t;
        t = '{v, r, w, 2'b01, r, 1'b1, 1'b1, 1'b0, 4'h5, 16'h0100, a, sd, rdat, n};
        return t;
    endfunction

    task automatic chk1(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // reset with an access presented: nothing may be requested or stalled
        valid_in = 1; MemRead_in = 1; ALU_result_in = 16'h0033;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_stall", 16'(stall), 16'h0);
        chk1("reset_mem_req", 16'(bus.mem_req), 16'h0);
        chk1("reset_mem_we", 16'(bus.mem_we), 16'h0);
        chk1("reset_mem_out", Mem_out_next, 16'h0);
        chk1("reset_mem_err", 16'(mem_err), 16'h0);
        valid_in = 0; MemRead_in = 0;
        rst_n = 1;
        @(posedge clk);
        #1;
        mon_en = 1;

        send(mk(1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 1), 1);   // ALU op, zero latency
        send(mk(1, 1, 0, 16'h0040, 16'h0000, 16'hBEEF, 3), 1);   // load, 3 WAIT cycles
        send(mk(1, 0, 1, 16'h0010, 16'h00AA, 16'h5A5A, 1), 1);   // store, ack in first WAIT
        send(mk(1, 1, 1, 16'h0020, 16'h1111, 16'h7777, 2), 1);   // read+write treated as store

        // stray acks everywhere outside the request; load must wait for its own
        stray_force = 1;
        send(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1), 1);
        send(mk(1, 1, 0, 16'h0044, 16'h0000, 16'hC0DE, 2), 1);
        stray_force = 0;

        // back-to-back loads and random stream
        send(mk(1, 1, 0, 16'h0050, 16'h0000, 16'h1357, 1), 1);
        send(mk(1, 1, 0, 16'h0052, 16'h0000, 16'h2468, 1), 1);
        for (int i = 0; i < 60; i++) send(rand_txn(), 1);

`ifdef MEM_TIMEOUT_EN
        send(mk(1, 1, 0, 16'h0060, 16'h0000, 16'hDEAD, 0), 1);   // never acked
`endif

        // reset in the middle of WAIT, then a late ack
        mon_en = 0;
        mem_q.push_back('{16'h0055, 16'h0000, 16'h0000, 1'b0, 0});
        valid_in = 1; MemRead_in = 1; MemWrite_in = 0;
        ALU_result_in = 16'h0055; store_data_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk1("wait_mem_req", 16'(bus.mem_req), 16'h1);
        #2 rst_n = 0;
        #1;
        chk1("midwait_reset_req", 16'(bus.mem_req), 16'h0);
        chk1("midwait_reset_stall", 16'(stall), 16'h0);
        valid_in = 0; MemRead_in = 0;
        @(negedge clk);
        rst_n = 1;
        stray_force = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("post_reset_req", 16'(bus.mem_req), 16'h0);
            chk1("post_reset_stall", 16'(stall), 16'h0);
            chk1("post_reset_mem_out", Mem_out_next, 16'h0);
        end
        stray_force = 0;
        @(posedge clk);
        #1;
        mon_en = 1;
        send(mk(1, 1, 0, 16'h0070, 16'h0000, 16'hFACE, 2), 1);
        send(mk(1, 0, 0, 16'h4321, 16'h0000, 16'h0000, 1), 1);

        chk1("scoreboard_drained", 16'(exp_q.size() + mem_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
